fwd_hazard_unit: RTL and testbench

- Parametrised, registered forwarding and hazard unit for the 5-stage ARM pipeline; next generation of the combinational forwarding unit.
- Resolves operand sources in ID against the EXE and MEM destinations, then registers the per-operand forwarding selects into the ID/EXE boundary.
- Adds load-use stall detection, a non-forwarding fallback mode, freeze handling and a saturating stall counter.
- Sits beside the hazard logic; drives the EXE-stage operand muxes and the IF/ID stall.

---
 rtl/fwd_hazard_unit_pkg.sv | 23 ++
 rtl/fwd_src_compare.sv | 31 +++
 rtl/fwd_hazard_unit.sv | 81 ++++++++
 tb/tb_fwd_hazard_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared select encodings and widths for the forwarding/hazard unit
package fwd_hazard_unit_pkg;

    localparam int REG_ADDRESS_LEN = 4;
    localparam int FWD_SEL_LEN     = 2;

    typedef enum logic [FWD_SEL_LEN-1:0] {
        FWD_SEL_RF  = 2'b00,
        FWD_SEL_MEM = 2'b01,
        FWD_SEL_WB  = 2'b10
    } fwd_sel_e;

    // EXE match wins over MEM match: the EXE instruction is the newer producer
    function automatic fwd_sel_e fwd_pick(input logic hit_e, input logic hit_m);
        if (hit_e)
            return FWD_SEL_MEM;
        else if (hit_m)
            return FWD_SEL_WB;
        else
            return FWD_SEL_RF;
    endfunction

endpackage

// File: rtl/fwd_src_compare.sv
// rtl/fwd_src_compare.sv - per-operand destination compare and forwarding select
module fwd_src_compare
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDRESS_LEN
) (
    input  logic [REG_ADDR_W-1:0]  src,
    input  logic                   used,
    input  logic                   en_forwarding,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_read,
    input  logic [REG_ADDR_W-1:0]  exe_dst,
    input  logic                   mem_wb_en,
    input  logic [REG_ADDR_W-1:0]  mem_dst,
    output logic [FWD_SEL_LEN-1:0] next_sel,
    output logic                   load_use_hit,
    output logic                   nofwd_hit
);

    logic hit_e;
    logic hit_m;

    // An operand that is not read never matches; a WB-stage match needs no action
    assign hit_e = used & exe_wb_en & (src == exe_dst);
    assign hit_m = used & mem_wb_en & (src == mem_dst);

    assign next_sel     = en_forwarding ? fwd_pick(hit_e, hit_m) : FWD_SEL_RF;
    assign load_use_hit = hit_e & exe_mem_read;
    assign nofwd_hit    = hit_e | hit_m;

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - registered operand forwarding selects, load-use stall and stall counter
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDRESS_LEN,
    parameter int NUM_SRC    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_forwarding,
    input  logic                            freeze,
    input  logic                            id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]              id_src_used,
    input  logic                            exe_wb_en,
    input  logic                            exe_mem_read,
    input  logic [REG_ADDR_W-1:0]           exe_dst,
    input  logic                            mem_wb_en,
    input  logic [REG_ADDR_W-1:0]           mem_dst,
    input  logic                            stat_clr,
    output logic                            hazard_stall,
    output logic [NUM_SRC*FWD_SEL_LEN-1:0]  exe_sel,
    output logic                            exe_fwd_any,
    output logic [CNT_W-1:0]                stall_cnt
);

    logic [NUM_SRC*FWD_SEL_LEN-1:0] next_sel;
    logic [NUM_SRC-1:0]             load_use_vec;
    logic [NUM_SRC-1:0]             nofwd_vec;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_compare #(
            .REG_ADDR_W(REG_ADDR_W)
        ) u_cmp (
            .src          (id_src[i*REG_ADDR_W +: REG_ADDR_W]),
            .used         (id_src_used[i]),
            .en_forwarding(en_forwarding),
            .exe_wb_en    (exe_wb_en),
            .exe_mem_read (exe_mem_read),
            .exe_dst      (exe_dst),
            .mem_wb_en    (mem_wb_en),
            .mem_dst      (mem_dst),
            .next_sel     (next_sel[i*FWD_SEL_LEN +: FWD_SEL_LEN]),
            .load_use_hit (load_use_vec[i]),
            .nofwd_hit    (nofwd_vec[i])
        );
    end

    // With forwarding only a load in EXE forces a stall; without it any in-flight producer does
    assign hazard_stall = id_valid & (en_forwarding ? (|load_use_vec) : (|nofwd_vec));

    // ID/EXE select register: hold on freeze, bubble on stall or empty ID slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_sel     <= '0;
            exe_fwd_any <= 1'b0;
        end else if (!freeze) begin
            if (hazard_stall || !id_valid) begin
                exe_sel     <= '0;
                exe_fwd_any <= 1'b0;
            end else begin
                exe_sel     <= next_sel;
                exe_fwd_any <= |next_sel;
            end
        end
    end

    // Saturating stall counter; clear beats increment, freeze beats both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!freeze) begin
            if (stat_clr)
                stall_cnt <= '0;
            else if (hazard_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit against a behavioural model
module tb_fwd_hazard_unit;

    localparam int AW  = 4;
    localparam int NS  = 3;
    localparam int CW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_forwarding;
    logic          freeze;
    logic          id_valid;
    logic [NS*AW-1:0] id_src;
    logic [NS-1:0] id_src_used;
    logic          exe_wb_en;
    logic          exe_mem_read;
    logic [AW-1:0] exe_dst;
    logic          mem_wb_en;
    logic [AW-1:0] mem_dst;
    logic          stat_clr;
    logic          hazard_stall;
    logic [NS*2-1:0] exe_sel;
    logic          exe_fwd_any;
    logic [CW-1:0] stall_cnt;

    fwd_hazard_unit #(.REG_ADDR_W(AW), .NUM_SRC(NS), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_forwarding(en_forwarding),
        .freeze       (freeze),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .exe_dst      (exe_dst),
        .mem_wb_en    (mem_wb_en),
        .mem_dst      (mem_dst),
        .stat_clr     (stat_clr),
        .hazard_stall (hazard_stall),
        .exe_sel      (exe_sel),
        .exe_fwd_any  (exe_fwd_any),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int sel;
        int any;
        int cnt;
    } reg_exp_t;

    typedef struct {
        int cyc;
        int stall;
    } comb_exp_t;

    reg_exp_t  reg_q[$];
    comb_exp_t comb_q[$];

    int cur_cycle = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    int m_sel [NS];
    int m_cnt;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d: got %0d expected %0d", name, cur_cycle, got, exp);
        end
    endtask

    // Monitor: registered outputs from the previous edge and the current stall flag
    initial begin
        reg_exp_t  r;
        comb_exp_t c;
        forever begin
            @(negedge clk);
            while (reg_q.size() > 0 && reg_q[0].cyc < cur_cycle) begin
                r = reg_q.pop_front();
                chk("exe_sel", int'(exe_sel), r.sel);
                chk("exe_fwd_any", int'(exe_fwd_any), r.any);
                chk("stall_cnt", int'(stall_cnt), r.cnt);
            end
            while (comb_q.size() > 0 && comb_q[0].cyc <= cur_cycle) begin
                c = comb_q.pop_front();
                chk("hazard_stall", int'(hazard_stall), c.stall);
            end
        end
    end

    // Reference model: apply the pipeline rules to the current inputs, then advance one clock
    task automatic do_cycle();
        int stall = 0;
        int nsel [NS];
        int packed_sel = 0;
        int any = 0;
        for (int i = 0; i < NS; i++) begin
            int s = int'(id_src[i*AW +: AW]);
            bit he = id_src_used[i] && exe_wb_en && (s == int'(exe_dst));
            bit hm = id_src_used[i] && mem_wb_en && (s == int'(mem_dst));
            if (en_forwarding) begin
                nsel[i] = he ? 1 : (hm ? 2 : 0);
                if (he && exe_mem_read) stall = 1;
            end else begin
                nsel[i] = 0;
                if (he || hm) stall = 1;
            end
        end
        if (!id_valid) stall = 0;
        comb_q.push_back('{cyc: cur_cycle, stall: stall});

        if (rst) begin
            for (int i = 0; i < NS; i++) m_sel[i] = 0;
            m_cnt = 0;
        end else if (!freeze) begin
            for (int i = 0; i < NS; i++) m_sel[i] = (stall || !id_valid) ? 0 : nsel[i];
            if (stat_clr) m_cnt = 0;
            else if (stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
        for (int i = 0; i < NS; i++) begin
            packed_sel += m_sel[i] * (1 << (2 * i));
            if (m_sel[i] != 0) any = 1;
        end
        reg_q.push_back('{cyc: cur_cycle, sel: packed_sel, any: any, cnt: m_cnt});

        @(posedge clk);
        #1;
        cur_cycle++;
    endtask

    // Reset in the middle of a cycle: outputs must clear before the next edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        reg_q.delete();
        reg_q.push_back('{cyc: cur_cycle - 1, sel: 0, any: 0, cnt: 0});
        for (int i = 0; i < NS; i++) m_sel[i] = 0;
        m_cnt = 0;
        do_cycle();
        rst = 1'b0;
    endtask

    task automatic set_idle();
        en_forwarding = 1'b1;
        freeze        = 1'b0;
        id_valid      = 1'b1;
        id_src        = {4'd14, 4'd13, 4'd12};
        id_src_used   = 3'b111;
        exe_wb_en     = 1'b0;
        exe_mem_read  = 1'b0;
        exe_dst       = 4'd0;
        mem_wb_en     = 1'b0;
        mem_dst       = 4'd0;
        stat_clr      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        for (int i = 0; i < NS; i++) m_sel[i] = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        do_cycle();
        rst = 1'b0;

        // EXE ALU result forwarded to operand 0
        exe_wb_en = 1; exe_dst = 2; id_src[3:0] = 2;
        do_cycle();
        // EXE and MEM both write r3: EXE wins; then MEM alone
        set_idle(); id_src[7:4] = 3; exe_wb_en = 1; exe_dst = 3; mem_wb_en = 1; mem_dst = 3;
        do_cycle();
        exe_wb_en = 0;
        do_cycle();
        // Load-use: one stall cycle, then the load moves to MEM
        set_idle(); id_src[3:0] = 5; exe_wb_en = 1; exe_mem_read = 1; exe_dst = 5;
        do_cycle();
        exe_wb_en = 0; exe_mem_read = 0; exe_dst = 0; mem_wb_en = 1; mem_dst = 5;
        do_cycle();
        // Forwarding off: MEM producer stalls; unused operand does not
        set_idle(); en_forwarding = 0; mem_wb_en = 1; mem_dst = 1; id_src[11:8] = 1;
        do_cycle();
        id_src_used[2] = 0;
        do_cycle();
        // R15 is not special
        set_idle(); id_src[11:8] = 15; exe_wb_en = 1; exe_dst = 15;
        do_cycle();
        // Freeze with a stall active, clear requested under freeze
        set_idle(); id_src[3:0] = 7; exe_wb_en = 1; exe_mem_read = 1; exe_dst = 7;
        do_cycle();
        freeze = 1;
        do_cycle();
        stat_clr = 1;
        do_cycle();
        do_cycle();
        freeze = 0;
        do_cycle();
        // Continuous stall saturates the counter
        stat_clr = 0;
        for (int k = 0; k < 5; k++) do_cycle();
        // Clear and increment together: clear wins
        stat_clr = 1;
        do_cycle();
        stat_clr = 0;
        for (int k = 0; k < 2; k++) do_cycle();
        // Asynchronous reset mid-stall
        do_reset();
        set_idle();

        // Randomized traffic with small address range to force collisions
        for (int k = 0; k < 400; k++) begin
            en_forwarding = ($urandom_range(0, 3) != 0);
            freeze        = ($urandom_range(0, 9) == 0);
            id_valid      = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NS; i++)
                id_src[i*AW +: AW] = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            id_src_used   = 3'($urandom_range(0, 7));
            exe_wb_en     = $urandom_range(0, 1) == 1;
            exe_mem_read  = $urandom_range(0, 2) == 0;
            exe_dst       = 4'($urandom_range(0, 3));
            mem_wb_en     = $urandom_range(0, 1) == 1;
            mem_dst       = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            stat_clr      = ($urandom_range(0, 19) == 0);
            if (k % 97 == 50) do_reset();
            else do_cycle();
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", reg_q.size() + comb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
